// File: rtl/scan_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | scan_seq_pkg                                                               |
// | Command opcodes and FSM state encoding for the scan-chain sequencer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package scan_seq_pkg;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_DUMP = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LD_WAIT  = 3'd1,
        ST_LD_SHIFT = 3'd2,
        ST_DP_SHIFT = 3'd3,
        ST_DP_WAIT  = 3'd4,
        ST_RUN      = 3'd5,
        ST_STEP     = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/scan_byte_serdes.sv
// +----------------------------------------------------------------------------+
// | scan_byte_serdes                                                           |
// | 8-bit shift buffer with bit index: serialises LOAD bytes, gathers DUMP.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module scan_byte_serdes
    import scan_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic       capture,
    input  logic [7:0] byte_in,
    input  logic       bit_in,
    output logic       bit_out,
    output logic [7:0] byte_out,
    output logic [2:0] bit_idx
);

    logic [7:0] r_shreg;
    logic [2:0] r_idx;

    // load has priority: it starts every byte, including the zero-fill before a dump byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shreg <= 8'h00;
            r_idx   <= 3'd0;
        end else if (load) begin
            r_shreg <= byte_in;
            r_idx   <= 3'd0;
        end else if (shift) begin
            r_shreg <= {1'b0, r_shreg[7:1]};
            r_idx   <= r_idx + 3'd1;
        end else if (capture) begin
            r_shreg[r_idx] <= bit_in;
            r_idx          <= r_idx + 3'd1;
        end
    end

    assign bit_out  = r_shreg[0];
    assign byte_out = r_shreg;
    assign bit_idx  = r_idx;

endmodule

`default_nettype wire

// File: rtl/scan_chain_sequencer.sv
// +----------------------------------------------------------------------------+
// | scan_chain_sequencer                                                       |
// | Host-driven LOAD/DUMP/RUN/STEP sequencer owning the core scan chain.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module scan_chain_sequencer
    import scan_seq_pkg::*;
#(
    parameter int CHAIN_LEN = 280,
    parameter int RUN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [RUN_W-1:0] run_limit,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [7:0]       din,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [7:0]       dout,
    output logic             scan_enable,
    output logic             scan_in,
    input  logic             scan_out,
    output logic             proc_enable,
    input  logic             proc_halted,
    output logic             done,
    output logic             timeout
);

    localparam int            c_cnt_w     = $clog2(CHAIN_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit  = c_cnt_w'(CHAIN_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_chain_len = c_cnt_w'(CHAIN_LEN);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_bc;
    logic [RUN_W-1:0]   r_rc;
    logic [RUN_W-1:0]   r_limit;
    logic               r_done;
    logic               r_timeout;

    logic               w_cmd_fire;
    logic               w_last_shift;
    logic               w_chain_full;
    logic               w_limit_hit;
    logic [RUN_W:0]     w_rc_next;
    logic               w_sd_load;
    logic               w_sd_shift;
    logic               w_sd_capture;
    logic [7:0]         w_sd_byte_in;
    logic               w_sd_bit_out;
    logic [7:0]         w_sd_byte_out;
    logic [2:0]         w_sd_bit_idx;

    // done occupies the first IDLE cycle, so the next command waits one cycle
    assign cmd_ready    = (r_state == ST_IDLE) && !r_done;
    assign w_cmd_fire   = cmd_valid && cmd_ready;
    assign w_last_shift = (w_sd_bit_idx == 3'd7) || (r_bc == c_last_bit);
    assign w_chain_full = (r_bc == c_chain_len);
    assign w_rc_next    = {1'b0, r_rc} + {{RUN_W{1'b0}}, 1'b1};
    assign w_limit_hit  = (r_limit != '0) && (w_rc_next == {1'b0, r_limit});

    assign w_sd_load    = ((r_state == ST_LD_WAIT) && din_valid)
                        || (w_cmd_fire && (cmd_op == CMD_DUMP))
                        || ((r_state == ST_DP_WAIT) && dout_ready && !w_chain_full);
    assign w_sd_byte_in = (r_state == ST_LD_WAIT) ? din : 8'h00;
    assign w_sd_shift   = (r_state == ST_LD_SHIFT);
    assign w_sd_capture = (r_state == ST_DP_SHIFT);

    scan_byte_serdes u_serdes (
        .clk      (clk),
        .rst      (rst),
        .load     (w_sd_load),
        .shift    (w_sd_shift),
        .capture  (w_sd_capture),
        .byte_in  (w_sd_byte_in),
        .bit_in   (scan_out),
        .bit_out  (w_sd_bit_out),
        .byte_out (w_sd_byte_out),
        .bit_idx  (w_sd_bit_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_bc      <= '0;
            r_rc      <= '0;
            r_limit   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_timeout <= 1'b0;
                        r_bc      <= '0;
                        unique case (cmd_op)
                            CMD_LOAD: r_state <= ST_LD_WAIT;
                            CMD_DUMP: r_state <= ST_DP_SHIFT;
                            CMD_STEP: r_state <= ST_STEP;
                            CMD_RUN: begin
                                r_limit <= run_limit;
                                r_rc    <= '0;
                                // an already-halted core completes without being enabled
                                if (proc_halted) r_done  <= 1'b1;
                                else             r_state <= ST_RUN;
                            end
                        endcase
                    end
                end
                ST_LD_WAIT: begin
                    if (din_valid) r_state <= ST_LD_SHIFT;
                end
                ST_LD_SHIFT: begin
                    r_bc <= r_bc + c_cnt_w'(1);
                    if (w_last_shift) begin
                        if (r_bc == c_last_bit) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_LD_WAIT;
                        end
                    end
                end
                ST_DP_SHIFT: begin
                    r_bc <= r_bc + c_cnt_w'(1);
                    if (w_last_shift) r_state <= ST_DP_WAIT;
                end
                ST_DP_WAIT: begin
                    if (dout_ready) begin
                        if (w_chain_full) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DP_SHIFT;
                        end
                    end
                end
                ST_RUN: begin
                    // halt is checked first so it wins over a coincident limit
                    if (proc_halted) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else if (w_limit_hit) begin
                        r_state   <= ST_IDLE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (r_rc != {RUN_W{1'b1}}) begin
                        r_rc <= w_rc_next[RUN_W-1:0];
                    end
                end
                ST_STEP: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign din_ready   = (r_state == ST_LD_WAIT);
    assign dout_valid  = (r_state == ST_DP_WAIT);
    assign dout        = (r_state == ST_DP_WAIT) ? w_sd_byte_out : 8'h00;
    assign scan_enable = (r_state == ST_LD_SHIFT) || (r_state == ST_DP_SHIFT);
    assign scan_in     = (r_state == ST_LD_SHIFT) ? w_sd_bit_out :
                         (r_state == ST_DP_SHIFT) ? scan_out     : 1'b0;
    assign proc_enable = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign done        = r_done;
    assign timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_scan_chain_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_scan_chain_sequencer                                                    |
// | Randomised bench with a core/chain model and a stream-level reference.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_scan_chain_sequencer;
    import scan_seq_pkg::*;

    localparam int L  = 20;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [RW-1:0] run_limit = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [7:0]    din = 8'h00;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [7:0]    dout;
    logic          scan_enable;
    logic          scan_in;
    logic          scan_out;
    logic          proc_enable;
    logic          proc_halted;
    logic          done;
    logic          timeout;

    scan_chain_sequencer #(.CHAIN_LEN(L), .RUN_W(RW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .run_limit(run_limit),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
        .proc_enable(proc_enable), .proc_halted(proc_halted),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // core model: chain head is bit L-1, tail is bit 0
    logic [L-1:0] chain = '0;
    int           exec_cnt = 0;
    int           halt_at = 0;
    logic         core_clr = 1'b0;

    always @(posedge clk) begin
        if (scan_enable) chain <= {scan_in, chain[L-1:1]};
        if (core_clr) exec_cnt <= 0;
        else if (proc_enable) exec_cnt <= exec_cnt + 1;
    end
    assign scan_out    = chain[0];
    assign proc_halted = (halt_at != 0) && (exec_cnt >= halt_at - 1);

    int se_cnt = 0;
    int pe_cnt = 0;
    always @(negedge clk) begin
        if (scan_enable) se_cnt <= se_cnt + 1;
        if (proc_enable) pe_cnt <= pe_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("excl_enable", 32'(scan_enable & proc_enable), 32'd0);
            check("ready_idle_only",
                  32'(cmd_ready & (scan_enable | proc_enable | din_ready | dout_valid | done)), 32'd0);
        end
    end

    logic [L-1:0] ref_chain = '0;

    // stream bit i lands at chain bit i once all L bits are shifted in
    function automatic logic [L-1:0] ref_load(input logic [7:0] b0, b1, b2);
        logic [23:0] s;
        s = {b2, b1, b0};
        return s[L-1:0];
    endfunction

    function automatic void ref_run(input int lim, input int h, output int en, output int to);
        if (h == 1) begin
            en = 0; to = 0;
        end else if (lim != 0 && (h == 0 || lim < h)) begin
            en = lim; to = 1;
        end else begin
            en = h; to = 0;
        end
    endfunction

    task automatic check_reset_outputs();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_outputs", 32'({din_ready, dout_valid, dout, scan_enable, scan_in,
                                  proc_enable, done, timeout}), 32'd0);
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [RW-1:0] lim);
        int t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; run_limit = lim;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ready_drop", 32'(cmd_ready), 32'd0);
        check("timeout_clear", 32'(timeout), 32'd0);
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while (!done && t < bound) begin @(negedge clk); t++; end
        check("done_seen", 32'(done), 32'd1);
        check("done_not_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("done_pulse_ready", 32'({done, cmd_ready}), 32'b01);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        din = b; din_valid = 1'b1;
        while (!din_ready && t < 50) begin @(negedge clk); t++; end
        check("din_ready_wait", 32'(din_ready), 32'd1);
        @(negedge clk);
        din_valid = 1'b0; din = 8'($urandom);
        check("din_ready_drop", 32'(din_ready), 32'd0);
    endtask

    task automatic load_chain(input logic [7:0] b0, b1, b2);
        int s0 = se_cnt;
        issue_cmd(CMD_LOAD, '0);
        send_byte(b0); send_byte(b1); send_byte(b2);
        wait_done(20);
        ref_chain = ref_load(b0, b1, b2);
        check("load_se_cycles", 32'(se_cnt - s0), 32'(L));
        check("load_chain", 32'(chain), 32'(ref_chain));
    endtask

    task automatic dump_chain(input int hold_first);
        logic [23:0]  img = 24'(ref_chain);
        logic [L-1:0] c0 = chain;
        logic [7:0]   exp;
        int           t, hold;
        issue_cmd(CMD_DUMP, '0);
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!dout_valid && t < 30) begin @(negedge clk); t++; end
            check("dout_valid_wait", 32'(dout_valid), 32'd1);
            exp = img[8*k +: 8];
            check($sformatf("dout%0d", k), 32'(dout), 32'(exp));
            hold = (k == 0) ? hold_first : $urandom_range(0, 3);
            repeat (hold) begin
                @(negedge clk);
                check("dout_stable", 32'({dout_valid, dout}), 32'({1'b1, exp}));
            end
            dout_ready = 1'b1;
            @(negedge clk);
            dout_ready = 1'b0;
            check("dout_valid_drop", 32'(dout_valid), 32'd0);
        end
        wait_done(5);
        check("dump_chain_kept", 32'(chain), 32'(c0));
    endtask

    task automatic run_cmd(input int lim, input int h);
        int p0, en, to;
        halt_at = h;
        core_clr = 1'b1;
        @(negedge clk);
        core_clr = 1'b0;
        ref_run(lim, h, en, to);
        p0 = pe_cnt;
        issue_cmd(CMD_RUN, RW'(lim));
        wait_done(300);
        check($sformatf("run_en_cycles(l=%0d,h=%0d)", lim, h), 32'(pe_cnt - p0), 32'(en));
        check($sformatf("run_timeout(l=%0d,h=%0d)", lim, h), 32'(timeout), 32'(to));
    endtask

    task automatic step_cmd();
        int p0;
        halt_at = 0;
        p0 = pe_cnt;
        issue_cmd(CMD_STEP, '0);
        wait_done(5);
        check("step_en_cycles", 32'(pe_cnt - p0), 32'd1);
        check("step_timeout", 32'(timeout), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int op, lim, h;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        @(negedge clk);

        load_chain(8'hA5, 8'h3C, 8'h0F);
        dump_chain(5);

        run_cmd(0, 7);
        run_cmd(4, 0);
        step_cmd();
        run_cmd(5, 5);
        run_cmd(0, 1);

        // reset while the second byte is shifting
        issue_cmd(CMD_LOAD, '0);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        check("mid_shift", 32'(scan_enable), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_outputs();
        load_chain(8'($urandom), 8'($urandom), 8'($urandom));
        dump_chain(0);

        for (int i = 0; i < 12; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    load_chain(8'($urandom), 8'($urandom), 8'($urandom));
                    dump_chain($urandom_range(0, 3));
                end
                1: begin
                    lim = $urandom_range(0, 12);
                    h   = $urandom_range(0, 12);
                    if (lim == 0 && h == 0) lim = 3;
                    run_cmd(lim, h);
                end
                2: step_cmd();
                default: dump_chain($urandom_range(0, 3));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
